seq_mult: RTL and testbench
===========================

# seq_mult

Parametrised, multi-cycle signed shift-add multiplier with valid/ready handshakes on input and output, and a run-time approximate mode. In approximate mode the low `APPROX_K` magnitude bits of `b` are dropped, which trades accuracy for fewer cycles. It is the sequential, width-generic successor to the team's combinational 3-bit exact multiplier. It sits between an operand source and a result sink that may each stall.

## Interface
Parameters:
- `W`, default 8: operand width (signed two's complement); legal range 2..32.
- `APPROX_K`, default 2: number of low magnitude bits of `b` ignored in approximate mode; legal range 0..W-1.

Ports:
- `clk`  in  1  rising-edge clock; the block uses one clock.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  operands `a`, `b` and `approx` are presented.
- `in_ready`  out  1  the block can accept an operand pair.
- `a`  in  W  signed multiplicand.
- `b`  in  W  signed multiplier.
- `approx`  in  1  1 = approximate mode, 0 = exact mode; sampled on accept.
- `out_valid`  out  1  `y` holds a completed product.
- `out_ready`  in  1  the sink takes `y`.
- `y`  out  2W  signed product.

## Operation
- Internal state is an enum of three values: IDLE, CALC, DONE.
- `in_ready` is 1 only when the state is IDLE and `rst` is 0.
- Accept condition: `in_valid && in_ready` on a rising edge. On accept the block latches:
  - `am = |a|` and `bm = |b|`, each as a W-bit unsigned value (|-2^(W-1)| = 2^(W-1) fits);
  - `neg = a[W-1] ^ b[W-1]`;
  - accumulator (2W bits) = 0;
  - bit index `i` = `approx ? APPROX_K : 0`;
  - `approx` itself.
- CALC, one iteration per cycle:
  - if `bm[i]` is 1, add `am << i` to the accumulator;
  - increment `i`;
  - after the iteration with `i = W-1`, write `y = neg ? -acc : acc` (2W-bit two's complement) and go to DONE.
- DONE:
  - `out_valid` = 1;
  - `y` holds constant until `out_ready` is sampled high;
  - on that edge `out_valid` drops to 0 and the state returns to IDLE.
- Results:
  - exact result equals `a*b` for every operand pair, including -2^(W-1) × -2^(W-1) = 2^(2W-2);
  - approximate result is `±(am × (bm & ~(2^APPROX_K - 1)))` with the sign given by `neg`;
  - a zero magnitude yields `y = 0` and never a negative value.
- Changes on `a`, `b`, `approx` or `in_valid` outside the accept edge have no effect.
- `APPROX_K = 0` makes the two modes identical.

## Timing
- Reset values: state IDLE, `out_valid` 0, `y` 0, accumulator 0, `in_ready` 0 while `rst` is high.
- Latency: `out_valid` rises N rising edges after the accept edge.
  - N = W in exact mode.
  - N = W - APPROX_K in approximate mode.
- Throughput: at most one operation per N+2 cycles. The next accept happens no earlier than the edge after the `out_ready` handshake, because `in_ready` is 0 throughout CALC and DONE.
- Backpressure: while `out_ready` is low in DONE, the state, `y` and `out_valid` are all frozen.
- If `out_ready` is already high when DONE is entered, the handshake completes on the first DONE edge, so `out_valid` is high for exactly one cycle.
- `rst` asserted in any state, including mid-CALC or in DONE with `out_valid` high: the next edge forces the reset values. The partial result is discarded and no `out_valid` pulse is emitted afterwards.
- `rst` has priority over a simultaneous accept or output handshake.

## Structure
- Package `seq_mult_pkg` holds the state enum typedef `seq_mult_state_t` (IDLE, CALC, DONE).
- A single sub-module is natural: `abs_w`.
  - Combinational, parameter W.
  - Outputs the W-bit unsigned magnitude and the sign bit of a W-bit signed input.
  - Instantiated once for `a` and once for `b`.
- Datapath (accumulator, index counter, final negation) and FSM live in `seq_mult`.

## Test plan
Scenarios use W=8, APPROX_K=2.
- Exact extreme: `a=-128`, `b=-128`, `approx=0`, `out_ready=1` -> `y=16384`, with `out_valid` rising 8 edges after accept and high for 1 cycle.
- Approximate truncation: `a=7`, `b=7`, `approx=1` -> `y=28` after 6 edges. Then `a=-5`, `b=3`, `approx=1` -> `y=0`. Then `a=-5`, `b=12`, `approx=1` -> `y=-60`.
- Backpressure: `a=3`, `b=-4`, `out_ready` held low for 5 cycles after `out_valid` rises -> `y=-12` stable, `in_ready=0`, and a new `in_valid` is ignored; release `out_ready` -> IDLE on the next edge.
- Reset mid-operation: accept `a=9`, `b=9`, pulse `rst` for 1 cycle after 4 CALC edges -> `out_valid=0`, `y=0`, `in_ready=1` the cycle after `rst` falls, and no late pulse.
- Random sweep: 2000 random pairs with random `approx` and random `out_ready` stalls, checked against a model -> every result matches `a*b`, or the truncated formula in approximate mode, with exactly one `out_valid` handshake per accept.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: shared state type for the sequential multiplier
package seq_mult_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} seq_mult_state_t;
endpackage

// File: rtl/seq_mult_abs.sv
// abs_w: unsigned magnitude and sign bit of a signed W-bit value
module abs_w #(
  parameter int W = 8
) (
  input  logic [W-1:0] x_i,
  output logic [W-1:0] mag_o,
  output logic         sgn_o
);
  assign sgn_o = x_i[W-1];
  assign mag_o = x_i[W-1] ? -x_i : x_i;
endmodule

// File: rtl/seq_mult.sv
// seq_mult: multi-cycle signed shift-add multiplier with optional approximate mode
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int W        = 8,
  parameter int APPROX_K = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           approx,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] y
);
  localparam int IW = $clog2(W);
  seq_mult_state_t state_q, state_d;
  logic [W-1:0]   am_q, am_d, bm_q, bm_d, a_mag, b_mag;
  logic           neg_q, neg_d, a_sgn, b_sgn;
  logic [2*W-1:0] acc_q, acc_d, acc_nxt, y_q, y_d;
  logic [IW-1:0]  i_q, i_d;
  abs_w #(.W(W)) u_abs_a (.x_i(a), .mag_o(a_mag), .sgn_o(a_sgn));
  abs_w #(.W(W)) u_abs_b (.x_i(b), .mag_o(b_mag), .sgn_o(b_sgn));
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign y         = y_q;
  assign acc_nxt   = acc_q + (bm_q[i_q] ? ({{W{1'b0}}, am_q} << i_q) : '0);
  // next state: latch magnitudes on accept, one partial product per CALC cycle, hold in DONE
  always_comb begin
    state_d = state_q;
    am_d    = am_q;
    bm_d    = bm_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    i_d     = i_q;
    y_d     = y_q;
    unique case (state_q)
      IDLE: if (in_valid && in_ready) begin
        state_d = CALC;
        am_d    = a_mag;
        bm_d    = b_mag;
        neg_d   = a_sgn ^ b_sgn;
        acc_d   = '0;
        i_d     = approx ? IW'(APPROX_K) : '0;
      end
      CALC: begin
        acc_d = acc_nxt;
        i_d   = i_q + IW'(1);
        if (i_q == IW'(W-1)) begin
          state_d = DONE;
          y_d     = neg_q ? -acc_nxt : acc_nxt;
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      am_q    <= '0;
      bm_q    <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      i_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      am_q    <= am_d;
      bm_q    <= bm_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      i_q     <= i_d;
      y_q     <= y_d;
    end
  end
endmodule

// File: tb/tb_seq_mult.sv
// tb_seq_mult: randomized self-checking bench for seq_mult against an arithmetic model
module tb_seq_mult;
  localparam int W = 8;
  localparam int K = 2;
  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           approx = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*W-1:0] y;
  int tests = 0;
  int fails = 0;
  int accepts = 0;
  int handshakes = 0;

  seq_mult #(.W(W), .APPROX_K(K)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .approx(approx), .out_valid(out_valid),
    .out_ready(out_ready), .y(y)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!rst && out_valid && out_ready) handshakes++;

  task automatic check(input string tag, input longint got, input longint exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic longint model(input int av, input int bv, input bit ap);
    longint am, bm, mag;
    am  = av < 0 ? -av : av;
    bm  = bv < 0 ? -bv : bv;
    if (ap) bm = bm - (bm % (1 << K));
    mag = am * bm;
    return ((av < 0) != (bv < 0)) ? -mag : mag;
  endfunction

  task automatic do_op(input int av, input int bv, input bit ap, input int stall);
    int n;
    longint exp;
    exp = model(av, bv, ap);
    n = 0;
    while (!in_ready && n < 40) begin step(); n++; end
    check("in_ready_wait", longint'(in_ready), 1);
    a = av[W-1:0];
    b = bv[W-1:0];
    approx = ap;
    out_ready = (stall == 0);
    in_valid = 1'b1;
    step();
    accepts++;
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    approx = 1'($urandom);
    n = 0;
    while (!out_valid && n < 40) begin step(); n++; end
    check("latency", n, ap ? W - K : W);
    check("y", longint'($signed(y)), exp);
    for (int k = 0; k < stall; k++) begin
      in_valid = 1'b1;
      a = W'($urandom);
      b = W'($urandom);
      step();
      check("stall_y", longint'($signed(y)), exp);
      check("stall_valid", longint'(out_valid), 1);
      check("stall_in_ready", longint'(in_ready), 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    check("valid_drop", longint'(out_valid), 0);
    check("idle_ready", longint'(in_ready), 1);
  endtask

  initial begin
    int highs;
    step();
    step();
    check("rst_in_ready", longint'(in_ready), 0);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_y", longint'(y), 0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", longint'(in_ready), 1);
    do_op(-128, -128, 1'b0, 0);
    do_op(7, 7, 1'b1, 0);
    do_op(-5, 3, 1'b1, 0);
    do_op(-5, 12, 1'b1, 0);
    do_op(3, -4, 1'b0, 5);
    do_op(0, -7, 1'b0, 0);
    do_op(-128, 127, 1'b1, 2);
    a = 8'd9;
    b = 8'd9;
    approx = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    rst = 1'b1;
    #1;
    check("mid_rst_ready", longint'(in_ready), 0);
    step();
    rst = 1'b0;
    #1;
    check("mid_rst_valid", longint'(out_valid), 0);
    check("mid_rst_y", longint'(y), 0);
    check("mid_rst_ready_after", longint'(in_ready), 1);
    highs = 0;
    for (int k = 0; k < 15; k++) begin step(); if (out_valid) highs++; end
    check("no_late_pulse", highs, 0);
    for (int t = 0; t < 2000; t++)
      do_op(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
            1'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
    check("handshakes", handshakes, accepts);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
